// File: rtl/magnetron_pkg.sv
// magnetron_pkg
// Shared definitions for the magnetron controller and its neighbours
// (latch and timer benches): FSM state codes, pulse kinds and the
// default debounce / pulse widths.
package magnetron_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COOK    = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      PLS_NONE = 2'd0,
      PLS_SET  = 2'd1,
      PLS_RST  = 2'd2
   } pulse_e;

   localparam int DEB_CYC_DEF   = 4;
   localparam int PULSE_CYC_DEF = 2;

endpackage

// File: rtl/magnetron_ctrl_debouncer.sv
// debouncer
// Two-flop synchronizer followed by a run-length debouncer. The output
// level only follows the input once DEB_CYC consecutive equal samples
// have been seen.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   raw_i       raw asynchronous input
//   level_o     debounced level (0 out of reset)
//   settled_o   1 once any level has been accepted since reset
module debouncer
   import magnetron_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic settled_o
);

   localparam int CW = $clog2(DEB_CYC + 1);

   logic [1:0]    sync_q, sync_d;
   // vld_pipe marks when the synchronizer holds real samples rather than
   // its reset zeros, so reset fill cannot count toward a stable run.
   logic [1:0]    vld_pipe_q, vld_pipe_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          settled_q, settled_d;

   always_comb begin
      sync_d     = {sync_q[0], raw_i};
      vld_pipe_d = {vld_pipe_q[0], 1'b1};
      last_d     = last_q;
      cnt_d      = cnt_q;
      level_d    = level_q;
      settled_d  = settled_q;
      if (vld_pipe_q[1]) begin
         last_d = sync_q[1];
         if (cnt_q == '0 || sync_q[1] != last_q)
            cnt_d = CW'(1);
         else if (cnt_q != CW'(DEB_CYC))
            cnt_d = cnt_q + CW'(1);
         if (cnt_d == CW'(DEB_CYC)) begin
            level_d   = sync_q[1];
            settled_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         vld_pipe_q <= '0;
         last_q     <= 1'b0;
         cnt_q      <= '0;
         level_q    <= 1'b0;
         settled_q  <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         vld_pipe_q <= vld_pipe_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         level_q    <= level_d;
         settled_q  <= settled_d;
      end
   end

   assign level_o   = level_q;
   assign settled_o = settled_q;

endmodule

// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl
// Debounces start/stop/door, runs the IDLE/COOK/PAUSE FSM and drives
// fixed-width set/reset pulses to the downstream magnetron SR latch.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start_btn         raw start button (active high)
//   stop_btn          raw stop/cancel button (active high)
//   door_closed       raw door switch, 1 = closed
//   timer_done        synchronous cook-timer expiry level
//   S, R              set / reset pulses to the latch, never both high
//   state_o           current FSM state code
module magnetron_ctrl
   import magnetron_pkg::*;
#(
   parameter int DEB_CYC   = DEB_CYC_DEF,
   parameter int PULSE_CYC = PULSE_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic       stop_btn,
   input  logic       door_closed,
   input  logic       timer_done,
   output logic       S,
   output logic       R,
   output logic [1:0] state_o
);

   localparam int PCW = 4;

   // Bit 0 = start, 1 = stop, 2 = door
   logic [2:0] raw_in, deb_lvl, deb_set;
   assign raw_in = {door_closed, stop_btn, start_btn};

   for (genvar i = 0; i < 3; i++) begin : g_deb
      debouncer #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (raw_in[i]),
         .level_o  (deb_lvl[i]),
         .settled_o(deb_set[i])
      );
   end

   logic [1:0] prev_q, prev_d, armed_q, armed_d, ev_q, ev_d;
   state_e     state_q, state_d;
   pulse_e     req, pend_q, pend_d, launch;
   logic       s_q, s_d, r_q, r_d;
   logic [PCW-1:0] cnt_q, cnt_d;
   logic       door_ok, start_ev, stop_ev, busy;

   assign door_ok  = deb_lvl[2] & deb_set[2];
   assign start_ev = ev_q[0];
   assign stop_ev  = ev_q[1];
   assign busy     = s_q | r_q;

   always_comb begin
      // A button is armed only after a released level has been accepted,
      // so a button held through reset release never fires.
      armed_d = armed_q | (deb_set[1:0] & ~deb_lvl[1:0]);
      prev_d  = deb_lvl[1:0];
      ev_d    = deb_lvl[1:0] & ~prev_q & armed_q;

      state_d = state_q;
      req     = PLS_NONE;
      case (state_q)
         ST_IDLE:
            if (start_ev && !stop_ev && door_ok && !timer_done) begin
               state_d = ST_COOK;
               req     = PLS_SET;
            end
         ST_COOK:
            if (!door_ok) begin
               state_d = ST_PAUSE;
               req     = PLS_RST;
            end else if (stop_ev || timer_done) begin
               state_d = ST_IDLE;
               req     = PLS_RST;
            end
         ST_PAUSE:
            if (stop_ev)
               state_d = ST_IDLE;
            else if (start_ev && door_ok && !timer_done) begin
               state_d = ST_COOK;
               req     = PLS_SET;
            end
         default: begin
            state_d = ST_IDLE;
            req     = PLS_RST;
         end
      endcase

      // A request during an active pulse cuts it and is parked for one
      // cycle, guaranteeing a low cycle before the next pulse.
      if (req != PLS_NONE)
         launch = busy ? PLS_NONE : req;
      else
         launch = pend_q;
      pend_d = (req != PLS_NONE && busy) ? req : PLS_NONE;

      s_d   = s_q;
      r_d   = r_q;
      cnt_d = cnt_q;
      if (launch != PLS_NONE) begin
         s_d   = (launch == PLS_SET);
         r_d   = (launch == PLS_RST);
         cnt_d = PCW'(PULSE_CYC - 1);
      end else if (req != PLS_NONE || (busy && cnt_q == '0)) begin
         s_d   = 1'b0;
         r_d   = 1'b0;
         cnt_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q - PCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '0;
         armed_q <= '0;
         ev_q    <= '0;
         state_q <= ST_IDLE;
         pend_q  <= PLS_NONE;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         prev_q  <= prev_d;
         armed_q <= armed_d;
         ev_q    <= ev_d;
         state_q <= state_d;
         pend_q  <= pend_d;
         s_q     <= s_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
      end
   end

   assign S       = s_q;
   assign R       = r_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_magnetron_ctrl.sv
// tb_magnetron_ctrl
// Directed stimulus against magnetron_ctrl. A behavioural model built from
// sample-history windows and a pulse schedule is compared every cycle;
// directed scenarios also check hand-computed latencies and pulse counts.
module tb_magnetron_ctrl;
   localparam int DEB = 4;
   localparam int PUL = 2;
   localparam int N   = 2048;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_btn = 1'b0, stop_btn = 1'b0, door_closed = 1'b0, timer_done = 1'b0;
   logic       S, R;
   logic [1:0] state_o;

   int n_chk = 0;
   int n_pass = 0;

   magnetron_ctrl #(.DEB_CYC(DEB), .PULSE_CYC(PUL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_btn  (start_btn),
      .stop_btn   (stop_btn),
      .door_closed(door_closed),
      .timer_done (timer_done),
      .S          (S),
      .R          (R),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   bit raw_h [3][N];
   bit deb_h [3][N];
   bit set_h [3][N];
   bit sched_s [N];
   bit sched_r [N];
   int ncyc = 0;
   int m_s = 0, m_r = 0, m_st = 0;

   initial begin : model
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            ncyc = 0; m_s = 0; m_r = 0; m_st = 0;
            for (int i = 0; i < N; i++) begin
               sched_s[i] = 0; sched_r[i] = 0;
               for (int b = 0; b < 3; b++) begin
                  raw_h[b][i] = 0; deb_h[b][i] = 0; set_h[b][i] = 0;
               end
            end
         end else if (ncyc < N - 8) begin : step
            int e, nst, req;
            bit same, ev_s, ev_p, door, act;
            e = ncyc;
            raw_h[0][e] = start_btn;
            raw_h[1][e] = stop_btn;
            raw_h[2][e] = door_closed;
            // debounced level at edge e: raw sampled at e-2 after DEB equal samples
            for (int b = 0; b < 3; b++) begin
               deb_h[b][e] = (e > 0) ? deb_h[b][e-1] : 1'b0;
               set_h[b][e] = (e > 0) ? set_h[b][e-1] : 1'b0;
               if (e >= DEB + 1) begin
                  same = 1;
                  for (int j = 1; j < DEB; j++)
                     if (raw_h[b][e-2-j] != raw_h[b][e-2]) same = 0;
                  if (same) begin
                     deb_h[b][e] = raw_h[b][e-2];
                     set_h[b][e] = 1;
                  end
               end
            end
            // event seen by the FSM: debounced rise one edge earlier, from a settled low
            ev_s = (e >= 3) && deb_h[0][e-2] && !deb_h[0][e-3] && set_h[0][e-3];
            ev_p = (e >= 3) && deb_h[1][e-2] && !deb_h[1][e-3] && set_h[1][e-3];
            door = (e >= 1) && deb_h[2][e-1];
            nst = m_st;
            req = 0;
            case (m_st)
               0: if (ev_s && !ev_p && door && !timer_done) begin nst = 1; req = 1; end
               1: if (!door) begin nst = 2; req = 2; end
                  else if (ev_p || timer_done) begin nst = 0; req = 2; end
               2: if (ev_p) nst = 0;
                  else if (ev_s && door && !timer_done) begin nst = 1; req = 1; end
               default: begin nst = 0; req = 2; end
            endcase
            if (req != 0) begin
               act = (m_s != 0) || (m_r != 0);
               for (int k = e; k <= e + PUL + 1; k++) begin
                  sched_s[k] = 0; sched_r[k] = 0;
               end
               for (int k = 0; k < PUL; k++) begin
                  if (req == 1) sched_s[e + k + (act ? 1 : 0)] = 1;
                  else          sched_r[e + k + (act ? 1 : 0)] = 1;
               end
            end
            m_st = nst;
            m_s  = sched_s[e];
            m_r  = sched_r[e];
            ncyc = e + 1;
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            chk("S_model", int'(S), m_s);
            chk("R_model", int'(R), m_r);
            chk("state_model", int'(state_o), m_st);
            chk("S_and_R", int'(S & R), 0);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_cnt(input int n, output int s_cyc, output int r_cyc,
                          output int s_rise, output int r_rise,
                          output int first_s, output int first_r);
      logic ps, pr;
      s_cyc = 0; r_cyc = 0; s_rise = 0; r_rise = 0; first_s = 0; first_r = 0;
      ps = S; pr = R;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (S) begin
            s_cyc++;
            if (!ps) s_rise++;
            if (first_s == 0) first_s = i;
         end
         if (R) begin
            r_cyc++;
            if (!pr) r_rise++;
            if (first_r == 0) first_r = i;
         end
         ps = S; pr = R;
      end
   endtask

   initial begin : stim
      int sc, rc, sr, rr, fs, fr, sc2, rc2;
      // reset state
      idle(2);
      chk("rst_S", int'(S), 0);
      chk("rst_R", int'(R), 0);
      chk("rst_state", int'(state_o), 0);
      rst_n = 1'b1;
      door_closed = 1'b1;
      idle(12);

      // start press: 8-cycle latency, 2-cycle S, IDLE -> COOK
      start_btn = 1'b1;
      run_cnt(10, sc, rc, sr, rr, fs, fr);
      chk("start_latency", fs, 8);
      chk("start_S_width", sc, 2);
      chk("start_R_quiet", rc, 0);
      chk("start_state", int'(state_o), 1);
      start_btn = 1'b0;
      idle(10);

      // timer expiry in COOK -> R pulse, IDLE; start blocked while timer_done
      timer_done = 1'b1;
      run_cnt(6, sc, rc, sr, rr, fs, fr);
      chk("timer_R_first", fr, 1);
      chk("timer_R_width", rc, 2);
      chk("timer_state", int'(state_o), 0);
      start_btn = 1'b1;
      run_cnt(10, sc, rc, sr, rr, fs, fr);
      start_btn = 1'b0;
      run_cnt(10, sc2, rc2, sr, rr, fs, fr);
      chk("timer_blocks_S", sc + sc2, 0);
      chk("timer_blocks_state", int'(state_o), 0);
      timer_done = 1'b0;
      idle(2);

      // back to COOK
      start_btn = 1'b1;
      run_cnt(10, sc, rc, sr, rr, fs, fr);
      chk("cook2_latency", fs, 8);
      start_btn = 1'b0;
      idle(10);

      // stop event and door opening reach the FSM together: door wins
      stop_btn = 1'b1;
      idle(1);
      door_closed = 1'b0;
      run_cnt(15, sc, rc, sr, rr, fs, fr);
      chk("door_R_pulses", rr, 1);
      chk("door_R_width", rc, 2);
      chk("door_no_S", sc, 0);
      chk("door_state_pause", int'(state_o), 2);
      stop_btn = 1'b0;
      idle(10);
      stop_btn = 1'b1;
      run_cnt(12, sc, rc, sr, rr, fs, fr);
      chk("pause_stop_no_R", rc, 0);
      chk("pause_stop_no_S", sc, 0);
      chk("pause_stop_state", int'(state_o), 0);
      stop_btn = 1'b0;
      door_closed = 1'b1;
      idle(10);

      // bouncing start 1-0-1 then held -> one S pulse
      start_btn = 1'b1; idle(1);
      start_btn = 1'b0; idle(1);
      start_btn = 1'b1;
      run_cnt(20, sc, rc, sr, rr, fs, fr);
      chk("bounce_S_pulses", sr, 1);
      chk("bounce_S_width", sc, 2);
      chk("bounce_state", int'(state_o), 1);
      start_btn = 1'b0;
      idle(8);
      stop_btn = 1'b1;
      run_cnt(12, sc, rc, sr, rr, fs, fr);
      chk("stop_R_pulses", rr, 1);
      chk("stop_state", int'(state_o), 0);
      stop_btn = 1'b0;
      idle(10);

      // start then stop one cycle apart: S cut, one low cycle, 2-cycle R
      start_btn = 1'b1;
      idle(1);
      stop_btn = 1'b1;
      run_cnt(20, sc, rc, sr, rr, fs, fr);
      chk("cut_S_first", fs, 7);
      chk("cut_S_width", sc, 1);
      chk("cut_R_first", fr, 9);
      chk("cut_R_width", rc, 2);
      chk("cut_state", int'(state_o), 0);
      start_btn = 1'b0;
      stop_btn = 1'b0;
      idle(10);

      // reset during S pulse, start held through release
      start_btn = 1'b1;
      run_cnt(8, sc, rc, sr, rr, fs, fr);
      chk("pre_rst_S_first", fs, 8);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_S", int'(S), 0);
      chk("midrst_R", int'(R), 0);
      chk("midrst_state", int'(state_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_cnt(30, sc, rc, sr, rr, fs, fr);
      chk("held_no_S", sc, 0);
      chk("held_no_R", rc, 0);
      chk("held_state", int'(state_o), 0);
      start_btn = 1'b0;
      idle(12);
      start_btn = 1'b1;
      run_cnt(12, sc, rc, sr, rr, fs, fr);
      chk("repress_S_pulses", sr, 1);
      chk("repress_latency", fs, 8);
      chk("repress_state", int'(state_o), 1);
      start_btn = 1'b0;
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/magnetron_ctrl.md
MAGNETRON_CTRL -- requirements
Module: magnetron_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 4: consecutive stable samples needed to accept a new button/door level (range 2..255).
REQ-002 Parameter PULSE_CYC, default 2: width in clocks of every S/R pulse to the latch (range 1..15).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start_btn  in  1  start push-button, raw, asynchronous, active-high.
REQ-006 stop_btn  in  1  stop/cancel push-button, raw, asynchronous, active-high.
REQ-007 door_closed  in  1  door switch, raw, asynchronous, 1 = closed.
REQ-008 timer_done  in  1  synchronous level from the cook timer, 1 = time expired.
REQ-009 S  out  1  set pulse to the downstream SR latch (magnetron on).
REQ-010 R  out  1  reset pulse to the downstream SR latch (magnetron off).
REQ-011 state_o  out  2  current FSM state code.

Function
REQ-012 start_btn, stop_btn and door_closed SHALL each pass a 2-flop synchronizer, then a debouncer updating its output only after DEB_CYC consecutive equal samples.
REQ-013 Debounced start/stop SHALL produce one-cycle rising-edge events; holding a button SHALL yield exactly one event.
REQ-014 FSM states: IDLE=0, COOK=1, PAUSE=2; code 3 is illegal and SHALL return to IDLE next cycle with an R pulse.
REQ-015 IDLE: start event with door closed and timer_done=0 -> COOK, issue S pulse; otherwise stay, no pulse.
REQ-016 COOK: door open -> PAUSE; else stop event -> IDLE; else timer_done=1 -> IDLE; each transition issues one R pulse.
REQ-017 PAUSE: stop event -> IDLE, no pulse; start event with door closed and timer_done=0 -> COOK with S pulse; door open ignores start.
REQ-018 Event priority in any cycle: door open > stop > timer_done > start.
REQ-019 A pulse SHALL assert on the cycle after the transition and last exactly PULSE_CYC cycles; S and R SHALL never be high together.
REQ-020 A new pulse requested while one is in progress SHALL terminate the current pulse and start the new one on the next cycle (one low cycle between opposite pulses).
REQ-021 Latency from raw start_btn rise to S high SHALL be 2 + DEB_CYC + 2 cycles (sync, debounce, edge, FSM/pulse register).
REQ-022 state_o SHALL be registered and equal the FSM state register.

Reset
REQ-023 rst_n low SHALL immediately force S=0, R=0, state_o=IDLE, synchronizers and debouncers to 0 (door treated open), pulse counter to 0.
REQ-024 Reset mid-pulse SHALL truncate the pulse immediately; no pulse SHALL be emitted on reset release.
REQ-025 Buttons held through reset release SHALL NOT produce an event until released and pressed again.

Structure
REQ-026 State codes, DEB_CYC/PULSE_CYC defaults SHALL live in shared package magnetron_pkg for reuse by the latch and timer benches.
REQ-027 Debouncer SHALL be one sub-module, debouncer, instantiated three times; pulse generation and FSM stay in magnetron_ctrl.

Verification
REQ-028 Door closed, start pressed 10 cycles -> S high 2 cycles after 8-cycle latency, state_o 0->1, R stays 0.
REQ-029 In COOK, assert timer_done -> R pulse 2 cycles, state_o=0; further start with timer_done=1 -> no S.
REQ-030 In COOK, open door and press stop in same cycle -> PAUSE with one R pulse; then stop -> IDLE, no pulse.
REQ-031 Button bouncing 1-0-1 at 1-cycle intervals for 3 cycles then stable high -> exactly one S pulse.
REQ-032 rst_n low during S pulse -> S=0 same cycle, state_o=0; release with start held -> no S until re-press.
REQ-033 Start event then stop event 1 cycle apart -> S truncated, one low cycle, then 2-cycle R; S&R never both 1.
